// File: rtl/writeback_queue_pkg.sv
// Shared widths, the zero-register constant and the queued-write record
// used by the writeback queue and its lookup helper.
package writeback_queue_pkg;

  localparam int unsigned WB_REG_W  = 6;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic [WB_REG_W-1:0] ZERO_REG = 6'd0;

  typedef struct packed {
    logic [WB_REG_W-1:0]         reg_idx;
    logic signed [WB_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer-side result handshake into the writeback queue.
interface writeback_queue_if;
  import writeback_queue_pkg::*;

  logic                        In_Valid;
  logic                        In_Ready;
  logic [WB_REG_W-1:0]         In_Reg;
  logic signed [WB_DATA_W-1:0] In_Data;

  modport master (output In_Valid, output In_Reg, output In_Data, input In_Ready);
  modport slave  (input In_Valid, input In_Reg, input In_Data, output In_Ready);

endinterface

// File: rtl/writeback_queue_lookup.sv
// Combinational youngest-match search; candidates are ordered oldest (index 0)
// to youngest, so the last valid match in the scan wins.
module wb_match_lookup
  import writeback_queue_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  entry_t                      cand [N],
  input  logic [N-1:0]                cand_valid,
  input  logic [WB_REG_W-1:0]         query,
  output logic                        hit,
  output logic signed [WB_DATA_W-1:0] fwd
);

  always_comb begin
    hit = 1'b0;
    fwd = '0;
    if (query != ZERO_REG) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (cand_valid[i] && (cand[i].reg_idx == query)) begin
          hit = 1'b1;
          fwd = cand[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Result queue draining one write per cycle into the register file, with
// read-after-write hit/forward lookup for two decode source operands.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                              Slow_Clock,
  input  logic                              Reset,
  input  logic                              Flush,
  input  logic                              Stall,
  writeback_queue_if.slave                  in_bus,
  output logic                              Reg_Write,
  output logic [WB_REG_W-1:0]               Reg_1,
  output logic signed [WB_DATA_W-1:0]       Write_Data,
  input  logic [WB_REG_W-1:0]               Query_A,
  input  logic [WB_REG_W-1:0]               Query_B,
  output logic                              Hit_A,
  output logic                              Hit_B,
  output logic signed [WB_DATA_W-1:0]       Fwd_A,
  output logic signed [WB_DATA_W-1:0]       Fwd_B,
  output logic [$clog2(DEPTH+1)-1:0]        Count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NC = DEPTH + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            in_ready;
  logic            accept;
  logic            enq;
  logic            deq;

  entry_t          cand [NC];
  logic [NC-1:0]   cand_valid;

  // Full queue refuses input even when it drains on the same edge.
  assign in_ready        = (count < CW'(DEPTH)) && !Flush;
  assign in_bus.In_Ready = in_ready;
  assign Count           = count;

  // Register-0 results finish the handshake but are never stored.
  assign accept = in_bus.In_Valid && in_ready && !Reset;
  assign enq    = accept && (in_bus.In_Reg != ZERO_REG);
  assign deq    = !Stall && (count != '0);

  always_ff @(posedge Slow_Clock) begin
    if (Reset || Flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      Reg_Write  <= 1'b0;
      Reg_1      <= '0;
      Write_Data <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (!Stall) begin
        if (deq) begin
          Reg_Write  <= 1'b1;
          Reg_1      <= mem[head].reg_idx;
          Write_Data <= mem[head].data;
          head       <= head + PW'(1);
        end else begin
          Reg_Write <= 1'b0;
        end
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Slow_Clock) begin
    if (enq) begin
      mem[tail] <= '{reg_idx: in_bus.In_Reg, data: in_bus.In_Data};
    end
  end

  // Candidate 0 is the write port register (oldest); then queue entries head-first.
  always_comb begin
    cand[0]       = '{reg_idx: Reg_1, data: Write_Data};
    cand_valid    = '0;
    cand_valid[0] = Reg_Write;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cand[i+1]       = mem[head + PW'(i)];
      cand_valid[i+1] = (CW'(i) < count);
    end
  end

  wb_match_lookup #(.N(NC)) u_lookup_a (
    .cand       (cand),
    .cand_valid (cand_valid),
    .query      (Query_A),
    .hit        (Hit_A),
    .fwd        (Fwd_A)
  );

  wb_match_lookup #(.N(NC)) u_lookup_b (
    .cand       (cand),
    .cand_valid (cand_valid),
    .query      (Query_B),
    .hit        (Hit_B),
    .fwd        (Fwd_B)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench: scoreboard of accepted writes compared against the
// register-file write port every cycle, plus per-scenario directed checks.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [WB_REG_W-1:0]         r;
    logic signed [WB_DATA_W-1:0] d;
  } wr_t;

  logic                        Slow_Clock = 1'b0;
  logic                        Reset;
  logic                        Flush;
  logic                        Stall;
  logic                        Reg_Write;
  logic [WB_REG_W-1:0]         Reg_1;
  logic signed [WB_DATA_W-1:0] Write_Data;
  logic [WB_REG_W-1:0]         Query_A;
  logic [WB_REG_W-1:0]         Query_B;
  logic                        Hit_A;
  logic                        Hit_B;
  logic signed [WB_DATA_W-1:0] Fwd_A;
  logic signed [WB_DATA_W-1:0] Fwd_B;
  logic [2:0]                  Count;

  int checks = 0;
  int errors = 0;

  wr_t sb[$];

  writeback_queue_if bus();

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .Slow_Clock (Slow_Clock),
    .Reset      (Reset),
    .Flush      (Flush),
    .Stall      (Stall),
    .in_bus     (bus),
    .Reg_Write  (Reg_Write),
    .Reg_1      (Reg_1),
    .Write_Data (Write_Data),
    .Query_A    (Query_A),
    .Query_B    (Query_B),
    .Hit_A      (Hit_A),
    .Hit_B      (Hit_B),
    .Fwd_A      (Fwd_A),
    .Fwd_B      (Fwd_B),
    .Count      (Count)
  );

  always #5 Slow_Clock = ~Slow_Clock;

  task automatic tick;
    @(negedge Slow_Clock);
  endtask

  // Predicts the write port from inputs sampled at each edge; compares 1 time unit later.
  task automatic monitor_writes;
    logic                        r, f, s, v;
    logic [WB_REG_W-1:0]         rg;
    logic signed [WB_DATA_W-1:0] d;
    logic                        exp_we;
    logic [WB_REG_W-1:0]         exp_reg;
    logic signed [WB_DATA_W-1:0] exp_data;
    logic                        acc;
    wr_t                         w;
    exp_we = 1'b0; exp_reg = '0; exp_data = '0;
    forever begin
      @(posedge Slow_Clock);
      r = Reset; f = Flush; s = Stall; v = bus.In_Valid; rg = bus.In_Reg; d = bus.In_Data;
      if (r || f) begin
        sb.delete();
        exp_we = 1'b0; exp_reg = '0; exp_data = '0;
      end else begin
        acc = v && (sb.size() < DEPTH);
        if (!s) begin
          if (sb.size() > 0) begin
            w = sb.pop_front();
            exp_we = 1'b1; exp_reg = w.r; exp_data = w.d;
          end else begin
            exp_we = 1'b0;
          end
        end
        if (acc && rg != ZERO_REG) begin
          w.r = rg; w.d = d;
          sb.push_back(w);
        end
      end
      #1;
      checks++;
      if (Reg_Write !== exp_we || (exp_we && (Reg_1 !== exp_reg || Write_Data !== exp_data))) begin
        errors++;
        $display("FAIL write_port: got we=%0b reg=%0d data=%0d, expected we=%0b reg=%0d data=%0d",
                 Reg_Write, Reg_1, Write_Data, exp_we, exp_reg, exp_data);
      end
      checks++;
      if (Count !== 3'(sb.size())) begin
        errors++;
        $display("FAIL count_track: got %0d, expected %0d", Count, sb.size());
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Flush = 1'b0; Stall = 1'b0;
    bus.In_Valid = 1'b0; bus.In_Reg = '0; bus.In_Data = '0;
    Query_A = '0; Query_B = '0;
    repeat (3) tick;
    Reset = 1'b0;
    tick;
    checks++;
    if (Count !== 3'd0 || bus.In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got count=%0d ready=%0b, expected count=0 ready=1", Count, bus.In_Ready);
    end
    checks++;
    if (Reg_Write !== 1'b0 || Reg_1 !== 6'd0 || Write_Data !== 32'sd0) begin
      errors++;
      $display("FAIL reset_port: got we=%0b reg=%0d data=%0d, expected 0 0 0", Reg_Write, Reg_1, Write_Data);
    end
  endtask

  task automatic test_basic;
    bus.In_Valid = 1'b1; bus.In_Reg = 6'd5; bus.In_Data = 32'sd100;
    tick;
    bus.In_Valid = 1'b0;
    checks++;
    if (Reg_Write !== 1'b0 || Count !== 3'd1) begin
      errors++;
      $display("FAIL basic_latency: got we=%0b count=%0d, expected we=0 count=1", Reg_Write, Count);
    end
    tick;
    checks++;
    if (Reg_Write !== 1'b1 || Reg_1 !== 6'd5 || Write_Data !== 32'sd100) begin
      errors++;
      $display("FAIL basic_write: got we=%0b reg=%0d data=%0d, expected 1 5 100", Reg_Write, Reg_1, Write_Data);
    end
    tick;
    checks++;
    if (Reg_Write !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got we=%0b, expected 0", Reg_Write);
    end
  endtask

  task automatic test_stall_full;
    logic signed [WB_DATA_W-1:0] exp_fwd;
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.In_Valid = 1'b1; bus.In_Reg = 6'(10 + i); bus.In_Data = -32'sd1000 * (i + 1);
      tick;
    end
    bus.In_Valid = 1'b0;
    checks++;
    if (Count !== 3'd4 || bus.In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got count=%0d ready=%0b, expected count=4 ready=0", Count, bus.In_Ready);
    end
    Query_A = 6'd11;
    exp_fwd = -32'sd2000;
    #1;
    checks++;
    if (Hit_A !== 1'b1 || Fwd_A !== exp_fwd) begin
      errors++;
      $display("FAIL full_query: got hit=%0b fwd=%0d, expected hit=1 fwd=%0d", Hit_A, Fwd_A, exp_fwd);
    end
    bus.In_Valid = 1'b1; bus.In_Reg = 6'd14; bus.In_Data = 32'sd14;
    tick;
    bus.In_Valid = 1'b0;
    checks++;
    if (Count !== 3'd4) begin
      errors++;
      $display("FAIL full_reject: got count=%0d, expected 4", Count);
    end
    Stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if (Reg_Write !== 1'b1 || Reg_1 !== 6'(10 + k)) begin
        errors++;
        $display("FAIL drain_order: got we=%0b reg=%0d, expected we=1 reg=%0d", Reg_Write, Reg_1, 10 + k);
      end
    end
    tick;
    checks++;
    if (Count !== 3'd0 || Reg_Write !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got count=%0d we=%0b, expected 0 0", Count, Reg_Write);
    end
    Query_A = '0;
  endtask

  task automatic test_same_reg;
    Stall = 1'b1;
    bus.In_Valid = 1'b1; bus.In_Reg = 6'd7; bus.In_Data = 32'sd1;
    tick;
    bus.In_Data = 32'sd2;
    tick;
    bus.In_Valid = 1'b0;
    Query_A = 6'd7; Query_B = 6'd7;
    #1;
    checks++;
    if (Hit_A !== 1'b1 || Fwd_A !== 32'sd2 || Hit_B !== 1'b1 || Fwd_B !== 32'sd2) begin
      errors++;
      $display("FAIL youngest_hit: got A=%0b/%0d B=%0b/%0d, expected 1/2 1/2", Hit_A, Fwd_A, Hit_B, Fwd_B);
    end
    Stall = 1'b0;
    tick;
    checks++;
    if (Write_Data !== 32'sd1 || Hit_A !== 1'b1 || Fwd_A !== 32'sd2) begin
      errors++;
      $display("FAIL youngest_mid: got data=%0d hit=%0b fwd=%0d, expected 1 1 2", Write_Data, Hit_A, Fwd_A);
    end
    tick;
    checks++;
    if (Write_Data !== 32'sd2 || Hit_A !== 1'b1 || Fwd_A !== 32'sd2) begin
      errors++;
      $display("FAIL outreg_hit: got data=%0d hit=%0b fwd=%0d, expected 2 1 2", Write_Data, Hit_A, Fwd_A);
    end
    tick;
    checks++;
    if (Hit_A !== 1'b0 || Fwd_A !== 32'sd0) begin
      errors++;
      $display("FAIL no_hit: got hit=%0b fwd=%0d, expected 0 0", Hit_A, Fwd_A);
    end
    Query_A = '0; Query_B = '0;
  endtask

  task automatic test_zero_reg;
    Query_A = 6'd0;
    bus.In_Valid = 1'b1; bus.In_Reg = 6'd0; bus.In_Data = 32'sd55;
    #1;
    checks++;
    if (bus.In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got %0b, expected 1", bus.In_Ready);
    end
    tick;
    bus.In_Valid = 1'b0;
    checks++;
    if (Count !== 3'd0 || Hit_A !== 1'b0 || Fwd_A !== 32'sd0) begin
      errors++;
      $display("FAIL zero_drop: got count=%0d hit=%0b fwd=%0d, expected 0 0 0", Count, Hit_A, Fwd_A);
    end
    tick;
    tick;
    checks++;
    if (Reg_Write !== 1'b0) begin
      errors++;
      $display("FAIL zero_nowrite: got we=%0b, expected 0", Reg_Write);
    end
  endtask

  task automatic test_flush;
    bus.In_Valid = 1'b1; bus.In_Reg = 6'd19; bus.In_Data = 32'sd190;
    tick;
    bus.In_Valid = 1'b0;
    tick;
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.In_Valid = 1'b1; bus.In_Reg = 6'(20 + i); bus.In_Data = 32'(200 + i);
      tick;
    end
    checks++;
    if (Count !== 3'd3 || Reg_Write !== 1'b1 || Reg_1 !== 6'd19) begin
      errors++;
      $display("FAIL flush_setup: got count=%0d we=%0b reg=%0d, expected 3 1 19", Count, Reg_Write, Reg_1);
    end
    Flush = 1'b1; bus.In_Reg = 6'd23; bus.In_Data = 32'sd230;
    #1;
    checks++;
    if (bus.In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %0b, expected 0", bus.In_Ready);
    end
    tick;
    Flush = 1'b0; bus.In_Valid = 1'b0; Stall = 1'b0;
    Query_A = 6'd20; Query_B = 6'd23;
    #1;
    checks++;
    if (Count !== 3'd0 || Reg_Write !== 1'b0 || Reg_1 !== 6'd0 || Write_Data !== 32'sd0) begin
      errors++;
      $display("FAIL flush_clear: got count=%0d we=%0b reg=%0d data=%0d, expected 0 0 0 0",
               Count, Reg_Write, Reg_1, Write_Data);
    end
    checks++;
    if (Hit_A !== 1'b0 || Hit_B !== 1'b0 || bus.In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_hits: got hitA=%0b hitB=%0b ready=%0b, expected 0 0 1", Hit_A, Hit_B, bus.In_Ready);
    end
    tick;
    tick;
    Query_A = '0; Query_B = '0;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      Stall = (i % 2 == 1);
      bus.In_Valid = 1'b1; bus.In_Reg = 6'(i + 1); bus.In_Data = $signed($urandom);
      tick;
      checks++;
      if (Count > 3'd4) begin
        errors++;
        $display("FAIL wrap_bound: got count=%0d, expected <= 4", Count);
      end
    end
    bus.In_Valid = 1'b0; Stall = 1'b0;
    repeat (8) tick;
    checks++;
    if (Count !== 3'd0 || Reg_Write !== 1'b0) begin
      errors++;
      $display("FAIL wrap_drain: got count=%0d we=%0b, expected 0 0", Count, Reg_Write);
    end
  endtask

  initial begin
    fork
      monitor_writes();
    join_none
    test_reset();
    test_basic();
    test_stall_full();
    test_same_reg();
    test_zero_reg();
    test_flush();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
